// File: rtl/mac_result_drain_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
//   Shared definitions for the MAC array result path: lane count, accumulator
//   width and type, lane-index width and the drain FSM state encoding.
//   Imported by mac_result_drain_if and mac_result_drain.
// -----------------------------------------------------------------------------
package mac_pkg;

   localparam int N_MAC  = 8;                // MAC lanes / result words per pass
   localparam int C_W    = 24;               // accumulator width
   localparam int IDX_W  = $clog2(N_MAC);    // width of a lane index
   localparam int WCNT_W = 4;                // settle counter, holds SETTLE-1 for SETTLE in 1..15

   typedef logic [C_W-1:0]   acc_t;
   typedef logic [IDX_W-1:0] idx_t;

   // CLR is only reachable when MAC_DRAIN_CLR_EN is defined.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2,
      CLR   = 2'd3
   } drain_state_e;

endpackage

// File: rtl/mac_result_drain_if.sv
// -----------------------------------------------------------------------------
// mac_result_drain_if
//   Valid/ready result stream from the drain stage to the result writer.
//     res_valid  master->slave  word available
//     res_ready  slave->master  consumer accepts word
//     res_data   master->slave  result word (C_W bits)
//     res_idx    master->slave  lane index of res_data
//     res_last   master->slave  high with the lane N_MAC-1 word
//   Modports: master (drain stage), slave (result writer).
// -----------------------------------------------------------------------------
interface mac_result_drain_if
   import mac_pkg::*;
#(
   parameter int DATA_W = C_W,
   parameter int IDXW   = IDX_W
);

   logic              res_valid;
   logic              res_ready;
   logic [DATA_W-1:0] res_data;
   logic [IDXW-1:0]   res_idx;
   logic              res_last;

   modport master (
      output res_valid,
      output res_data,
      output res_idx,
      output res_last,
      input  res_ready
   );

   modport slave (
      input  res_valid,
      input  res_data,
      input  res_idx,
      input  res_last,
      output res_ready
   );

endinterface

// File: rtl/mac_result_drain.sv
// -----------------------------------------------------------------------------
// mac_result_drain
//   Result drain stage behind the 8-lane MAC array. A falling edge on the
//   array's last-lane enable marks the end of a compute pass; SETTLE cycles
//   later all accumulators are snapshotted and then streamed out one word per
//   handshake. A pass end seen while already busy is dropped and flagged.
//
//   Parameters:
//     SETTLE    cycles from detected pass end to snapshot (legal 1..15)
//     N_MAC/C_W come from mac_pkg so array, drain and writer always agree.
//
//   Ports:
//     clk        sole clock
//     rst_n      synchronous active-low reset
//     done_tap   last-lane enable exported by the array
//     c_in       accumulator outputs of the array, one per lane
//     res        result stream (mac_result_drain_if.master)
//     busy       state is not IDLE
//     overrun    sticky: pass end seen while busy, cleared only by reset
//     clr_out    one-cycle accumulator clear request (MAC_DRAIN_CLR_EN only)
//
//   Build option:
//     MAC_DRAIN_CLR_EN  adds the CLR state and the clr_out port so the
//                       controller can auto-clear the array after each drain.
//                       Undefined: DRAIN returns straight to IDLE.
//
//   All outputs decode from registers only; res_ready never reaches an output
//   combinationally.
// -----------------------------------------------------------------------------
module mac_result_drain
   import mac_pkg::*;
#(
   parameter int SETTLE = 1
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    done_tap,
   input  acc_t                    c_in [N_MAC],
   mac_result_drain_if.master      res,
   output logic                    busy,
`ifdef MAC_DRAIN_CLR_EN
   output logic                    clr_out,
`endif
   output logic                    overrun
);

   drain_state_e      r_state;
   drain_state_e      w_next_state;
   logic              r_tap_q;
   logic [WCNT_W-1:0] r_wcnt;
   idx_t              r_idx;
   acc_t              r_snap [N_MAC];
   logic              r_overrun;

   logic              w_pass_end;
   logic              w_last;
   logic              w_hs;

   // Pass end: the enable was high last cycle and is low now.
   assign w_pass_end = r_tap_q & ~done_tap;
   assign w_last     = (r_idx == idx_t'(N_MAC - 1));
   // res_valid is exactly "state is DRAIN", so the handshake uses the state.
   assign w_hs       = (r_state == DRAIN) & res.res_ready;

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: every combinational output gets a default before the case so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         IDLE:  if (w_pass_end)     w_next_state = WAIT;
         WAIT:  if (r_wcnt == '0)   w_next_state = DRAIN;
         DRAIN: if (w_hs && w_last) begin
`ifdef MAC_DRAIN_CLR_EN
            w_next_state = CLR;
`else
            w_next_state = IDLE;
`endif
         end
`ifdef MAC_DRAIN_CLR_EN
         CLR:   w_next_state = IDLE;
`endif
         default: w_next_state = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: output decode (registered state and datapath only)
   // ---------------------------------------------------------------------------
   always_comb begin
      res.res_valid = 1'b0;
      res.res_data  = '0;
      res.res_idx   = '0;
      res.res_last  = 1'b0;
      busy          = (r_state != IDLE);
`ifdef MAC_DRAIN_CLR_EN
      clr_out       = 1'b0;
`endif
      unique case (r_state)
         DRAIN: begin
            res.res_valid = 1'b1;
            res.res_data  = r_snap[r_idx];
            res.res_idx   = r_idx;
            res.res_last  = w_last;
         end
`ifdef MAC_DRAIN_CLR_EN
         CLR:   clr_out = 1'b1;
`endif
         default: ;
      endcase
   end

   assign overrun = r_overrun;

   // ---------------------------------------------------------------------------
   // Datapath: edge-detect flop, settle counter, lane index, snapshot bank,
   // overrun flag.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_tap_q   <= 1'b0;
         r_wcnt    <= '0;
         r_idx     <= '0;
         r_overrun <= 1'b0;
         // NOTE: the snapshot bank is reset on purpose: outputs must read zero
         // straight out of reset, so this is flops, not a RAM.
         for (int i = 0; i < N_MAC; i++) r_snap[i] <= '0;
      end else begin
         r_tap_q <= done_tap;

         // Only IDLE accepts a pass end; anywhere else it is dropped and flagged.
         if (w_pass_end && (r_state != IDLE)) r_overrun <= 1'b1;

         unique case (r_state)
            IDLE: begin
               if (w_pass_end) r_wcnt <= WCNT_W'(SETTLE - 1);
            end
            WAIT: begin
               if (r_wcnt == '0) begin
                  for (int i = 0; i < N_MAC; i++) r_snap[i] <= c_in[i];
                  r_idx <= '0;
               end else begin
                  r_wcnt <= r_wcnt - 1'b1;
               end
            end
            DRAIN: begin
               // Stop at the last lane instead of wrapping; WAIT reloads idx.
               if (w_hs && !w_last) r_idx <= r_idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_result_drain.sv
// -----------------------------------------------------------------------------
// tb_mac_result_drain
//   Scoreboard bench for mac_result_drain. Each accepted pass end pushes the
//   eight expected words (taken from the c_in values the bench holds through
//   capture) into a queue; a negedge monitor pops and compares on every
//   handshake, checks hold stability under backpressure and the return to
//   idle (or the clr_out pulse when MAC_DRAIN_CLR_EN is defined).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mac_result_drain;
   import mac_pkg::*;

   localparam int SETTLE = 1;

   typedef struct {
      acc_t data;
      idx_t idx;
      logic last;
   } word_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic done_tap = 1'b0;
   acc_t c_in [N_MAC];
   logic busy;
   logic overrun;
`ifdef MAC_DRAIN_CLR_EN
   logic clr_out;
`endif

   mac_result_drain_if #(.DATA_W(C_W), .IDXW(IDX_W)) res_if ();

   mac_result_drain #(.SETTLE(SETTLE)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .done_tap (done_tap),
      .c_in     (c_in),
      .res      (res_if.master),
      .busy     (busy),
`ifdef MAC_DRAIN_CLR_EN
      .clr_out  (clr_out),
`endif
      .overrun  (overrun)
   );

   always #5 clk = ~clk;

   // Scoreboard state
   word_t exp_q[$];
   int    pop_cycles[$];
   int    checks = 0;
   int    failures = 0;
   int    cycle = 0;
   bit    model_overrun = 1'b0;
   bit    mon_hold_pending = 1'b0;
   word_t mon_held;
   int    post_last = 0;
   int    ready_mode = 0;
   int    ready_phase = 0;

   always @(posedge clk) cycle++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   function automatic logic clr_now();
`ifdef MAC_DRAIN_CLR_EN
      return clr_out;
`else
      return 1'b0;
`endif
   endfunction

   // Consumer ready: always, fixed 1,0,0,1 pattern, or random. Never looks at valid.
   always @(posedge clk) begin
      logic [3:0] pat;
      #1;
      pat = 4'b1001;
      case (ready_mode)
         0: res_if.res_ready = 1'b1;
         1: begin
            res_if.res_ready = pat[3 - ready_phase];
            ready_phase = (ready_phase + 1) % 4;
         end
         default: res_if.res_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor: everything sampled on the falling edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (mon_hold_pending) begin
            check("hold_valid", res_if.res_valid, 1);
            check("hold_data",  res_if.res_data,  mon_held.data);
            check("hold_idx",   res_if.res_idx,   mon_held.idx);
            check("hold_last",  res_if.res_last,  mon_held.last);
            mon_hold_pending = 1'b0;
         end

         if (post_last == 1) begin
`ifdef MAC_DRAIN_CLR_EN
            check("clr_pulse", clr_now(), 1);
            check("clr_busy",  busy, 1);
            check("clr_valid", res_if.res_valid, 0);
            post_last = 2;
`else
            check("after_last_busy",  busy, 0);
            check("after_last_valid", res_if.res_valid, 0);
            post_last = 0;
`endif
         end else if (post_last == 2) begin
            check("clr_single_cycle", clr_now(), 0);
            check("clr_then_idle",    busy, 0);
            post_last = 0;
         end else begin
            check("clr_quiet", clr_now(), 0);
         end

         if (res_if.res_valid && res_if.res_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_word: got idx %0d data 0x%0h, expected no word", res_if.res_idx, res_if.res_data);
            end else begin
               word_t w;
               w = exp_q.pop_front();
               check("word_data", res_if.res_data, w.data);
               check("word_idx",  res_if.res_idx,  w.idx);
               check("word_last", res_if.res_last, w.last);
               pop_cycles.push_back(cycle);
               if (w.last) post_last = 1;
            end
         end else if (res_if.res_valid) begin
            mon_held.data = res_if.res_data;
            mon_held.idx  = res_if.res_idx;
            mon_held.last = res_if.res_last;
            mon_hold_pending = 1'b1;
         end else begin
            check("quiet_outputs", {res_if.res_data, res_if.res_idx, res_if.res_last}, 0);
         end
      end
   end

   // Reference: one accepted pass produces c_in[0..N_MAC-1] in lane order.
   task automatic push_expected();
      for (int i = 0; i < N_MAC; i++) begin
         word_t w;
         w.data = c_in[i];
         w.idx  = idx_t'(i);
         w.last = (i == N_MAC - 1);
         exp_q.push_back(w);
      end
   endtask

   // Drive done_tap 1 then 0; returns 1ns after the edge that detects the fall.
   task automatic issue_pass(input bit while_busy);
      @(posedge clk); #1 done_tap = 1'b1;
      @(posedge clk); #1 done_tap = 1'b0;
      if (while_busy) model_overrun = 1'b1;
      else            push_expected();
      @(posedge clk); #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || post_last != 0) && n < 2000) begin
         @(posedge clk);
         n++;
      end
      check("drain_done_in_time", (n < 2000), 1);
      repeat (2) @(posedge clk);
      #1;
      check("idle_busy",    busy, 0);
      check("idle_valid",   res_if.res_valid, 0);
      check("overrun_flag", overrun, model_overrun);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"},   res_if.res_valid, 0);
      check({tag, "_data"},    res_if.res_data, 0);
      check({tag, "_idx"},     res_if.res_idx, 0);
      check({tag, "_last"},    res_if.res_last, 0);
      check({tag, "_busy"},    busy, 0);
      check({tag, "_overrun"}, overrun, 0);
      check({tag, "_clr"},     clr_now(), 0);
   endtask

   task automatic randomize_cin();
      for (int i = 0; i < N_MAC; i++) c_in[i] = acc_t'($urandom);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      res_if.res_ready = 1'b0;
      for (int i = 0; i < N_MAC; i++) c_in[i] = acc_t'(i * 24'h010101);

      // Reset held two cycles with done_tap high.
      rst_n = 1'b0;
      done_tap = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
         check_all_zero("reset");
      end

      // Release with done_tap still high, then drop it: a valid pass end.
      rst_n = 1'b1;
      @(posedge clk); #1 done_tap = 1'b0;
      push_expected();
      pop_cycles.delete();
      @(posedge clk); #1;                    // just after the detecting edge
      check("busy_after_pass_end", busy, 1);
      repeat (SETTLE) begin
         check("valid_before_capture", res_if.res_valid, 0);
         @(posedge clk); #1;
      end
      check("valid_after_capture", res_if.res_valid, 1);
      check("first_idx", res_if.res_idx, 0);
      wait_idle();
      check("basic_word_count", pop_cycles.size(), N_MAC);
      if (pop_cycles.size() == N_MAC)
         check("basic_consecutive", pop_cycles[N_MAC-1] - pop_cycles[0], N_MAC - 1);

      // Backpressure with a 1,0,0,1 ready pattern.
      ready_mode = 1;
      randomize_cin();
      issue_pass(1'b0);
      wait_idle();

      // Snapshot isolation: c_in overwritten one cycle after capture.
      ready_mode = 2;
      randomize_cin();
      issue_pass(1'b0);
      repeat (SETTLE) @(posedge clk);
      #1;
      for (int i = 0; i < N_MAC; i++) c_in[i] = 24'hFFFFFF;
      wait_idle();

      // Overrun: second pass end while draining.
      ready_mode = 1;
      randomize_cin();
      issue_pass(1'b0);
      begin
         int n = 0;
         while (exp_q.size() > 5 && n < 200) begin
            @(posedge clk);
            n++;
         end
         check("overrun_setup_in_time", (n < 200), 1);
      end
      issue_pass(1'b1);
      check("overrun_set", overrun, 1);
      wait_idle();

      // Random passes with random data, ready behaviour and gaps.
      for (int k = 0; k < 6; k++) begin
         ready_mode = $urandom_range(0, 2);
         randomize_cin();
         repeat ($urandom_range(0, 5)) @(posedge clk);
         issue_pass(1'b0);
         wait_idle();
      end

      // Reset in the middle of a drain, while lane 3 is presented.
      ready_mode = 0;
      randomize_cin();
      issue_pass(1'b0);
      begin
         int n = 0;
         while (exp_q.size() != 5 && n < 200) begin
            @(posedge clk);
            n++;
         end
         check("mid_reset_setup_in_time", (n < 200), 1);
      end
      #1;
      check("mid_reset_idx", res_if.res_idx, 3);
      rst_n = 1'b0;
      exp_q.delete();
      mon_hold_pending = 1'b0;
      post_last = 0;
      model_overrun = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         check_all_zero("mid_reset");
      end
      rst_n = 1'b1;

      // Normal operation resumes after the abandoned stream.
      randomize_cin();
      issue_pass(1'b0);
      wait_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mac_result_drain.md
# mac_result_drain

Result drain stage directly downstream of the 8-lane MAC array. It watches the array's last-lane enable to detect the end of a compute pass and snapshots all eight 24-bit accumulators. It then streams them out one per cycle over a valid/ready interface to the result writer. It also tells the controller when the array may be reused.

## Interface
Parameters:
- `N_MAC`, 8, number of MAC lanes / result words
- `C_W`, 24, accumulator width
- `SETTLE`, 1, cycles from detected pass end to snapshot (legal range 1..15)

Ports:
- `clk`  in  1  sole clock
- `rst_n`  in  1  reset, synchronous, active-low
- `done_tap`  in  1  last-lane enable from the array (lane `N_MAC-1` enable export)
- `c_in[0:N_MAC-1]`  in  C_W each  accumulator outputs of the array
- `res_valid`  out  1  result word available
- `res_ready`  in  1  consumer accepts word
- `res_data`  out  C_W  current result word
- `res_idx`  out  3  lane index of `res_data` (clog2 N_MAC)
- `res_last`  out  1  high with lane `N_MAC-1` word
- `busy`  out  1  state != IDLE
- `overrun`  out  1  sticky: pass end seen while busy
- `clr_out`  out  1  one-cycle accumulator clear request (only with `MAC_DRAIN_CLR_EN`)

## Operation
- States: IDLE, WAIT, DRAIN, CLR (CLR exists only with the macro).
- `done_tap` is registered into `tap_q`. A pass end is a rising edge of clk where `tap_q`=1 and `done_tap`=0.
- IDLE: on pass end, go to WAIT and load `wcnt`=SETTLE-1.
- WAIT: if `wcnt`=0, capture all `c_in` into snapshot regs, set `idx`=0 and go to DRAIN. Otherwise decrement `wcnt`.
- DRAIN:
  - `res_valid`=1, `res_data`=snap[idx], `res_idx`=idx, `res_last`=(idx==N_MAC-1).
  - On handshake (`res_valid`&`res_ready`), increment idx.
  - On handshake with `res_last`, go to CLR (macro on) or IDLE (macro off).
- CLR: `clr_out`=1 for exactly one cycle, then IDLE.
- Pass end while in WAIT, DRAIN or CLR: the pass end is ignored, no snapshot change, and `overrun` is set. `overrun` clears only on reset.
- The snapshot is frozen outside WAIT→DRAIN capture. `c_in` changes during DRAIN do not affect output.
- Widths: data passes through unmodified at C_W bits. No arithmetic other than counters. `idx` never wraps past N_MAC-1 within a pass.

## Timing
- Reset (rst_n low at edge): state IDLE, `tap_q`=0, `wcnt`=0, `idx`=0, snapshots 0. Outputs `res_valid`, `res_data`, `res_idx`, `res_last`, `busy`, `overrun`, `clr_out` all 0.
- Reset mid-drain: the next cycle is IDLE with all outputs 0. The partial stream is abandoned.
- Pass end detected at edge t: snapshot taken at edge t+SETTLE, `res_valid` high in cycle after t+SETTLE.
- `busy` is high from the cycle after edge t.
- With `res_ready` held high, the 8 words go out on 8 consecutive cycles.
- `res_valid`, `res_data`, `res_idx` and `res_last` are stable while `res_valid`=1 and `res_ready`=0. `res_valid` never drops without a handshake.
- `res_ready` does not depend on `res_valid`, and there is no combinational path from `res_ready` to any output.
- After the last handshake at edge e:
  - macro off: IDLE in cycle after e, `res_valid`=0.
  - macro on: `clr_out`=1 in cycle after e, IDLE the cycle after that.
- A pass end on the same edge the state returns to IDLE is an overrun. It is accepted only from IDLE.

## Configuration
- `MAC_DRAIN_CLR_EN` defined: the CLR state and `clr_out` port exist. The controller ORs `clr_out` into the array clear so the next pass starts from zero automatically.
- Undefined: there is no CLR state and no `clr_out` port. DRAIN returns directly to IDLE, and the controller owns clearing.

## Structure
- Shared package `mac_pkg`:
  - `N_MAC`, `C_W` constants
  - `acc_t` (logic [C_W-1:0])
  - `drain_state_e` enum (IDLE, WAIT, DRAIN, CLR)
  - index width localparam
- No sub-module. The block is a single module: edge detect, counter, snapshot bank, output mux and FSM.

## Test plan
- Reset check: `rst_n` low 2 cycles with `done_tap`=1 → all outputs 0, `busy`=0. Releasing with `done_tap` then dropping is a valid pass end.
- Basic drain: c_in[i]=i*0x010101, `done_tap` 1→0, `res_ready`=1, SETTLE=1 → `res_valid` two cycles after the falling-edge sample, then words 0x000000..0x070707 on 8 consecutive cycles. `res_last` only on idx 7, then IDLE.
- Backpressure: `res_ready` toggles 1,0,0,1… → each word held stable while stalled. All 8 delivered in order, with no duplicates or drops.
- Snapshot isolation: change all c_in to 0xFFFFFF one cycle after capture → streamed data still equals the pre-change values.
- Overrun: second `done_tap` fall during DRAIN → `overrun`=1 and remains set. The current stream is unaffected, and the state returns to IDLE after 8 words.
- Macro on: after the idx 7 handshake, `clr_out`=1 exactly one cycle and `busy` drops the next cycle. Reset asserted mid-DRAIN (idx 3) → next cycle all outputs 0 and `clr_out` does not pulse.
